// File: rtl/adc_arbiter.sv
// adc_arbiter: shares one ADC port between bemf, host and auto requesters with
// fixed priority, scanner anti-starvation, settle/go sequencing and timeout recovery.
module adc_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [15:0] TIMEOUT       = 16'hFFF0,
  parameter int unsigned STARVE_LIMIT  = 4
) (
  input  logic       clk3p2M,
  input  logic       reset,
  input  logic       bemf_req,
  input  logic       host_req,
  input  logic       auto_req,
  input  logic [3:0] bemf_chan,
  input  logic [3:0] host_chan,
  input  logic [3:0] auto_chan,
  input  logic       bemf_batt,
  input  logic       host_batt,
  input  logic       auto_batt,
  output logic       bemf_done,
  output logic       host_done,
  output logic       auto_done,
  output logic       bemf_err,
  output logic       host_err,
  output logic       auto_err,
  output logic [9:0] result_data,
  output logic [1:0] owner,
  output logic       busy,
  output logic       adc_go,
  output logic [3:0] adc_chan,
  output logic       adc_batt_sel,
  input  logic [9:0] adc_in,
  input  logic       adc_valid
);
  typedef enum logic [2:0] {IDLE, SETUP, GO, WAIT, DONE} state_t;
  state_t      state_q;
  logic [1:0]  owner_q;
  logic [3:0]  set_cnt_q;
  logic [15:0] tmo_q;
  logic [3:0]  starve_q;
  logic        go_q;
  logic [2:0]  done_q;
  logic [2:0]  err_q;
  logic [3:0]  chan_q;
  logic        batt_q;
  logic [9:0]  data_q;
  logic [1:0]  grant_d;
  logic [3:0]  chan_d;
  logic        batt_d;
  logic [2:0]  owner_oh;
  always_comb begin
    grant_d  = (auto_req && starve_q == 4'(STARVE_LIMIT)) ? 2'd3 :
               bemf_req ? 2'd1 : host_req ? 2'd2 : auto_req ? 2'd3 : 2'd0;
    chan_d   = grant_d == 2'd1 ? bemf_chan : grant_d == 2'd2 ? host_chan : auto_chan;
    batt_d   = grant_d == 2'd1 ? bemf_batt : grant_d == 2'd2 ? host_batt : auto_batt;
    owner_oh = {owner_q == 2'd1, owner_q == 2'd2, owner_q == 2'd3};
  end
  always_ff @(posedge clk3p2M) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= 2'd0;
      set_cnt_q <= 4'd0;
      tmo_q     <= 16'd0;
      starve_q  <= 4'd0;
      go_q      <= 1'b0;
      done_q    <= 3'b000;
      err_q     <= 3'b000;
      chan_q    <= 4'd0;
      batt_q    <= 1'b0;
      data_q    <= 10'd0;
    end else begin
      go_q   <= 1'b0;
      done_q <= 3'b000;
      err_q  <= 3'b000;
      case (state_q)
        IDLE: begin
          // owner stays visible through an err cycle and is replaced or cleared here
          owner_q <= grant_d;
          if (grant_d != 2'd0) begin
            chan_q    <= chan_d;
            batt_q    <= batt_d;
            set_cnt_q <= 4'd0;
            state_q   <= SETUP;
            starve_q  <= (grant_d == 2'd3 || !auto_req) ? 4'd0 :
                         starve_q == 4'(STARVE_LIMIT) ? starve_q : starve_q + 4'd1;
          end
        end
        SETUP: begin
          if (set_cnt_q == 4'(SETTLE_CYCLES)) begin
            go_q    <= 1'b1;
            state_q <= GO;
          end else set_cnt_q <= set_cnt_q + 4'd1;
        end
        GO: begin
          tmo_q   <= 16'd0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (adc_valid) begin
            data_q  <= adc_in;
            done_q  <= owner_oh;
            state_q <= DONE;
          end else if (tmo_q == TIMEOUT) begin
            err_q   <= owner_oh;
            state_q <= IDLE;
          end else tmo_q <= tmo_q + 16'd1;
        end
        DONE: begin
          owner_q <= 2'd0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign {bemf_done, host_done, auto_done} = done_q;
  assign {bemf_err, host_err, auto_err}    = err_q;
  assign result_data  = data_q;
  assign owner        = owner_q;
  assign busy         = state_q != IDLE;
  assign adc_go       = go_q;
  assign adc_chan     = chan_q;
  assign adc_batt_sel = batt_q;
endmodule

// File: tb/tb_adc_arbiter.sv
// tb_adc_arbiter: directed vector table, corner sequences and a randomized run
// checked against a transaction-level model of the arbitration rules.
`timescale 1ns/1ps
module tb_adc_arbiter;
  localparam int STARVE = 4;
  logic clk3p2M = 1'b0;
  logic reset = 1'b1;
  logic bemf_req = 1'b0, host_req = 1'b0, auto_req = 1'b0;
  logic [3:0] bemf_chan = 4'd3, host_chan = 4'd5, auto_chan = 4'd9;
  logic bemf_batt = 1'b1, host_batt = 1'b0, auto_batt = 1'b1;
  logic bemf_done, host_done, auto_done, bemf_err, host_err, auto_err;
  logic [9:0] result_data;
  logic [1:0] owner;
  logic busy, adc_go, adc_batt_sel;
  logic [3:0] adc_chan;
  logic [9:0] adc_in = 10'd0;
  logic adc_valid = 1'b0;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [2:0] req; logic [9:0] data; int dly; int exp;} vec_t;
  vec_t tbl[12];

  always #5 clk3p2M = ~clk3p2M;

  adc_arbiter dut (
    .clk3p2M(clk3p2M), .reset(reset),
    .bemf_req(bemf_req), .host_req(host_req), .auto_req(auto_req),
    .bemf_chan(bemf_chan), .host_chan(host_chan), .auto_chan(auto_chan),
    .bemf_batt(bemf_batt), .host_batt(host_batt), .auto_batt(auto_batt),
    .bemf_done(bemf_done), .host_done(host_done), .auto_done(auto_done),
    .bemf_err(bemf_err), .host_err(host_err), .auto_err(auto_err),
    .result_data(result_data), .owner(owner), .busy(busy), .adc_go(adc_go),
    .adc_chan(adc_chan), .adc_batt_sel(adc_batt_sel), .adc_in(adc_in), .adc_valid(adc_valid)
  );

  function automatic logic [2:0] oh(input int e);
    return e == 0 ? 3'b000 : 3'b100 >> (e - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk3p2M);
    #1;
  endtask

  task automatic grant(input logic [2:0] r, input int exp);
    {bemf_req, host_req, auto_req} = r;
    tick;
    chk("grant_owner", int'(owner), exp);
    chk("grant_chan", int'(adc_chan), exp == 1 ? 3 : exp == 2 ? 5 : 9);
    chk("grant_batt", int'(adc_batt_sel), exp == 2 ? 0 : 1);
  endtask

  task automatic wait_go;
    tick;
    tick;
    chk("go_early", int'(adc_go), 0);
    tick;
    chk("go_latency", int'(adc_go), 1);
  endtask

  task automatic respond(input logic [9:0] d, input int dly, input int exp);
    repeat (dly) tick;
    adc_valid = 1'b1;
    adc_in = d;
    tick;
    adc_valid = 1'b0;
    adc_in = 10'd0;
    chk("done_vec", int'({bemf_done, host_done, auto_done}), int'(oh(exp)));
    chk("err_vec", int'({bemf_err, host_err, auto_err}), 0);
    chk("result", int'(result_data), int'(d));
    chk("done_owner", int'(owner), exp);
    if (exp == 1) bemf_req = 1'b0; else if (exp == 2) host_req = 1'b0; else auto_req = 1'b0;
    tick;
    chk("idle_owner", int'(owner), 0);
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, starve, gcyc, vcyc, own, w;
    logic [2:0] samp, dn;
    logic [9:0] vdata;
    logic [3:0] sch[4];
    logic sbt[4];
    // {bemf,host,auto} request patterns; expected winners follow the starve count
    tbl[0]  = '{3'b100, 10'h011, 2, 1};
    tbl[1]  = '{3'b010, 10'h2A5, 3, 2};
    tbl[2]  = '{3'b001, 10'h3C0, 1, 3};
    tbl[3]  = '{3'b011, 10'h001, 4, 2};
    tbl[4]  = '{3'b101, 10'h155, 1, 1};
    tbl[5]  = '{3'b111, 10'h0AA, 2, 1};
    tbl[6]  = '{3'b011, 10'h3FF, 1, 2};
    tbl[7]  = '{3'b111, 10'h200, 3, 3};
    tbl[8]  = '{3'b110, 10'h07E, 1, 1};
    tbl[9]  = '{3'b011, 10'h101, 2, 2};
    tbl[10] = '{3'b101, 10'h1F0, 1, 1};
    tbl[11] = '{3'b001, 10'h0C3, 5, 3};
    tick;
    tick;
    chk("rst_owner", int'(owner), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_go", int'(adc_go), 0);
    chk("rst_chan", int'(adc_chan), 0);
    chk("rst_result", int'(result_data), 0);
    reset = 1'b0;
    tick;
    chk("idle_no_req", int'(busy), 0);
    for (int i = 0; i < 12; i++) begin
      grant(tbl[i].req, tbl[i].exp);
      wait_go;
      respond(tbl[i].data, tbl[i].dly, tbl[i].exp);
    end
    // simultaneous requests
    grant(3'b111, 1); wait_go; respond(10'h111, 1, 1);
    grant(3'b011, 2); wait_go; respond(10'h222, 1, 2);
    grant(3'b001, 3); wait_go; respond(10'h333, 1, 3);
    // bemf continuously with auto pending: four bemf then one auto
    for (int i = 0; i < 10; i++) begin
      grant(3'b101, (i % 5 == 4) ? 3 : 1);
      wait_go;
      respond(10'(i * 37 + 5), 1, (i % 5 == 4) ? 3 : 1);
    end
    // valid in the GO cycle is ignored
    grant(3'b010, 2);
    wait_go;
    adc_valid = 1'b1;
    adc_in = 10'h3FF;
    tick;
    adc_valid = 1'b0;
    chk("go_valid_ignored", int'({bemf_done, host_done, auto_done}), 0);
    respond(10'h123, 1, 2);
    // timeout with a pending host request behind it
    grant(3'b110, 1);
    wait_go;
    n = 0;
    while (!bemf_err && !host_err && !auto_err && !bemf_done && !host_done && !auto_done && n < 'hFFF2 + 8) begin
      tick;
      n++;
    end
    chk("tmo_cycles", n, 'hFFF2);
    chk("tmo_err_vec", int'({bemf_err, host_err, auto_err}), 3'b100);
    chk("tmo_done_vec", int'({bemf_done, host_done, auto_done}), 0);
    chk("tmo_result", int'(result_data), 'h123);
    bemf_req = 1'b0;
    tick;
    chk("tmo_next_owner", int'(owner), 2);
    chk("tmo_next_chan", int'(adc_chan), 5);
    wait_go;
    respond(10'h2A5, 2, 2);
    // reset in the middle of WAIT
    grant(3'b010, 2);
    wait_go;
    tick;
    tick;
    reset = 1'b1;
    tick;
    chk("mid_rst_owner", int'(owner), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_go", int'(adc_go), 0);
    chk("mid_rst_chan", int'(adc_chan), 0);
    chk("mid_rst_batt", int'(adc_batt_sel), 0);
    chk("mid_rst_result", int'(result_data), 0);
    chk("mid_rst_done", int'({bemf_done, host_done, auto_done}), 0);
    chk("mid_rst_err", int'({bemf_err, host_err, auto_err}), 0);
    reset = 1'b0;
    grant(3'b010, 2);
    wait_go;
    respond(10'h0F0, 2, 2);
    // randomized traffic against the transaction-level model
    {bemf_req, host_req, auto_req} = 3'b000;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    starve = 0;
    gcyc = -100;
    vcyc = -100;
    own = 0;
    vdata = 10'd0;
    for (int k = 0; k < 1500; k++) begin
      samp = {bemf_req, host_req, auto_req};
      sch[1] = bemf_chan; sch[2] = host_chan; sch[3] = auto_chan;
      sbt[1] = bemf_batt; sbt[2] = host_batt; sbt[3] = auto_batt;
      if (k == 0) samp = 3'b000;
      tick;
      if (k > 0 && !busy && own == 0 && gcyc < 0) gcyc = -100;
      if (k > 0 && (k - 1 == gcyc - 1 || 1'b1)) begin end
      if (k > 0 && own == 0) begin
        w = (samp[0] && starve == STARVE) ? 3 : samp[2] ? 1 : samp[1] ? 2 : samp[0] ? 3 : 0;
        chk("rnd_busy", int'(busy), w != 0 ? 1 : 0);
        chk("rnd_owner", int'(owner), w);
        if (w != 0) begin
          chk("rnd_chan", int'(adc_chan), int'(sch[w]));
          chk("rnd_batt", int'(adc_batt_sel), int'(sbt[w]));
          starve = (w == 3 || !samp[0]) ? 0 : (starve < STARVE ? starve + 1 : starve);
          own = w;
          gcyc = k;
        end
      end
      chk("rnd_go", int'(adc_go), k == gcyc + 3 ? 1 : 0);
      if (adc_go) begin
        vcyc = k + int'($urandom_range(1, 4));
        vdata = 10'($urandom);
      end
      dn = {bemf_done, host_done, auto_done};
      chk("rnd_done", int'(dn), k == vcyc + 1 ? int'(oh(own)) : 0);
      chk("rnd_err", int'({bemf_err, host_err, auto_err}), 0);
      if (k == vcyc + 1) begin
        chk("rnd_result", int'(result_data), int'(vdata));
        own = -1;
      end else if (own == -1) begin
        own = 0;
      end
      adc_valid = (k == vcyc);
      adc_in = adc_valid ? vdata : 10'($urandom);
      if (dn[2]) bemf_req = 1'b0;
      else if (!bemf_req && $urandom_range(0, 3) == 0) begin
        bemf_req = 1'b1; bemf_chan = 4'($urandom); bemf_batt = 1'($urandom);
      end
      if (dn[1]) host_req = 1'b0;
      else if (!host_req && $urandom_range(0, 3) == 0) begin
        host_req = 1'b1; host_chan = 4'($urandom); host_batt = 1'($urandom);
      end
      if (dn[0]) auto_req = 1'b0;
      else if (!auto_req && $urandom_range(0, 3) == 0) begin
        auto_req = 1'b1; auto_chan = 4'($urandom); auto_batt = 1'($urandom);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
